// File: rtl/i2s_pkg.sv
// Shared defaults, derived frame geometry and the channel type for the I2S DAC transmitter.
package i2s_pkg;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_SLOT_W   = 32;
    localparam int DEF_BCLK_DIV = 4;

    // Geometry of the default build; modules derive their own from their parameters.
    localparam int FRAME_W = 2 * DEF_SLOT_W;
    localparam int POS_W   = $clog2(FRAME_W);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic int frame_len(input int slot_w);
        return 2 * slot_w;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk_o every BCLK_DIV clk cycles and flags each falling edge.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk_o,
    output logic fall_tick_o
);

    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;
    logic             term;

    assign term = (cnt_q == CNT_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        bclk_d = bclk_q;
        if (term) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign fall_tick_o = term & bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-pair holding register, frame shift register, framing and handshake.
// Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-BCLK data delay).
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);

    localparam int FRAME_BITS = frame_len(SLOT_W);
    localparam int POS_BITS   = $clog2(FRAME_BITS);
    localparam int PAD_W      = SLOT_W - DATA_W;
    localparam logic [POS_BITS-1:0] POS_LAST  = POS_BITS'(FRAME_BITS - 1);
    localparam logic [POS_BITS-1:0] POS_RIGHT = POS_BITS'(SLOT_W);

    logic                  fall_tick;
    logic                  load;
    logic                  accept;
    logic [POS_BITS-1:0]   pos_q, pos_d;
    chan_e                 lrclk_q, lrclk_d;
    logic [DATA_W-1:0]     hold_l_q, hold_l_d;
    logic [DATA_W-1:0]     hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  armed_q, armed_d;
    logic                  ready_q, ready_d;
    logic                  underrun_q, underrun_d;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .bclk_o      (bclk),
        .fall_tick_o (fall_tick)
    );

    // A frame is loaded on the bclk fall that wraps the position back to 0.
    assign load   = fall_tick & (pos_q == POS_LAST);
    assign accept = sample_valid & ready_q;

    // Shifts rather than concatenation keep a zero-width pad legal.
    assign frame_word = (FRAME_BITS'(hold_l_q) << (FRAME_BITS - DATA_W))
                      | (FRAME_BITS'(hold_r_q) << PAD_W);

    always_comb begin
        pos_d       = pos_q;
        lrclk_d     = lrclk_q;
        shift_d     = shift_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        armed_d     = armed_q;
        underrun_d  = 1'b0;

        if (fall_tick) begin
            pos_d   = load ? '0 : pos_q + POS_BITS'(1);
            lrclk_d = (pos_d >= POS_RIGHT) ? CH_RIGHT : CH_LEFT;
            if (load) begin
                if (hold_full_q) begin
                    shift_d     = frame_word;
                    hold_full_d = 1'b0;
                end else begin
                    shift_d    = '0;
                    underrun_d = armed_q;
                end
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        // A pair accepted on a load tick waits for the next frame; it never bypasses.
        if (accept) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
            armed_d     = 1'b1;
        end

        ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_q       <= POS_LAST;
            lrclk_q     <= CH_LEFT;
            // NOTE: the sample stores are reset too, so a mid-frame reset can never replay stale audio.
            shift_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            lrclk_q     <= lrclk_d;
            shift_q     <= shift_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef I2S_LEFT_JUSTIFIED_EN
    assign sdata = shift_q[FRAME_BITS-1];
`else
    // One-BCLK delay: the bit crossing the frame boundary is the previous frame's pad zero.
    logic sdata_q, sdata_d;

    assign sdata_d = fall_tick ? shift_q[FRAME_BITS-1] : sdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sdata_q <= 1'b0;
        end else begin
            sdata_q <= sdata_d;
        end
    end

    assign sdata = sdata_q;
`endif

    assign lrclk        = lrclk_q;
    assign sample_ready = ready_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: cycle-level frame model plus directed literal frames.
module tb_i2s_dac_tx;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int DIV    = 2;
    localparam int FRAME  = 2 * SLOT_W;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [63:0] LIT_T2 = 64'h80000100_7FFFFF00;
    localparam logic [63:0] LIT_A  = 64'h12345600_65432100;
    localparam logic [63:0] LIT_B  = 64'hABCDEF00_000F0000;
    localparam logic [63:0] LIT_T6 = 64'h80000000_00000100;
`else
    localparam logic [63:0] LIT_T2 = 64'h40000080_3FFFFF80;
    localparam logic [63:0] LIT_A  = 64'h091A2B00_32A19080;
    localparam logic [63:0] LIT_B  = 64'h55E6F780_00078000;
    localparam logic [63:0] LIT_T6 = 64'h40000000_00000080;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] sample_l = '0;
    logic [DATA_W-1:0] sample_r = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready, bclk, lrclk, sdata, underrun;

    int n_checks = 0;
    int n_err    = 0;

    i2s_dac_tx #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (DIV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clk edges since reset release; bclk, frame position and
    // the transmitted word follow from plain arithmetic on that count.
    int              m_k = 0;
    bit              m_live = 0, m_pend = 0, m_armed = 0, m_ready = 0, m_under = 0;
    logic [23:0]     m_l = '0, m_r = '0;
    logic [63:0]     m_word = '0;

    function automatic int exp_pos(input int k);
        int nf;
        nf = k / (2 * DIV);
        return (nf == 0) ? FRAME - 1 : (nf - 1) % FRAME;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        if (!reset_n) begin
            m_live  = 1;
            m_k     = 0;
            m_pend  = 0;
            m_armed = 0;
            m_ready = 0;
            m_under = 0;
            m_word  = '0;
        end else if (m_live) begin
            acc = sample_valid && m_ready;
            m_k++;
            m_under = 0;
            if ((m_k % (2 * DIV) == 0) && (((m_k / (2 * DIV)) - 1) % FRAME == 0)) begin
                if (m_pend) begin
                    m_word = {m_l, 8'h00, m_r, 8'h00};
                    m_pend = 0;
                end else begin
                    m_word  = '0;
                    m_under = m_armed;
                end
            end
            if (acc) begin
                m_pend  = 1;
                m_l     = sample_l;
                m_r     = sample_r;
                m_armed = 1;
            end
            m_ready = !m_pend;
        end
    end

    always @(negedge clk) begin : compare
        int   nf, p;
        logic e_bclk, e_lr, e_sd;
        if (m_live) begin
            nf     = m_k / (2 * DIV);
            p      = exp_pos(m_k);
            e_bclk = ((m_k / DIV) % 2) == 1;
            e_lr   = (nf != 0) && (p >= SLOT_W);
`ifdef I2S_LEFT_JUSTIFIED_EN
            e_sd   = (nf == 0) ? 1'b0 : m_word[FRAME-1-p];
`else
            e_sd   = (nf == 0 || p == 0) ? 1'b0 : m_word[FRAME-p];
`endif
            check("cyc_bclk", {63'd0, bclk}, {63'd0, e_bclk});
            check("cyc_lrclk", {63'd0, lrclk}, {63'd0, e_lr});
            check("cyc_sdata", {63'd0, sdata}, {63'd0, e_sd});
            check("cyc_underrun", {63'd0, underrun}, {63'd0, m_under});
            check("cyc_ready", {63'd0, sample_ready}, {63'd0, m_ready});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [23:0] l, input logic [23:0] r, output bit ok);
        ok           = 0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        sample_valid = 1'b0;
        sample_l     = 24'hA5A5A5;
        sample_r     = 24'h5A5A5A;
    endtask

    task automatic wait_lr_fall(output bit ok);
        logic prev;
        ok   = 0;
        prev = lrclk;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (prev && !lrclk) begin
                ok = 1;
                break;
            end
            prev = lrclk;
        end
    endtask

    // Samples one whole frame, starting at the negedge where lrclk has just fallen.
    task automatic capture(output logic [63:0] bits, output bit ok);
        wait_lr_fall(ok);
        bits = '0;
        for (int i = 0; i < FRAME; i++) begin
            bits[63-i] = sdata;
            if (i < FRAME - 1) repeat (2 * DIV) @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit          ok, ok_a, ok_b, found;
        logic [63:0] fr, fa, fb;
        int          cnt, ones, t0, per, c;
        logic        pb;

        // 1: reset values and ready after release
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t1_rst_bclk", {63'd0, bclk}, 64'd0);
        check("t1_rst_lrclk", {63'd0, lrclk}, 64'd0);
        check("t1_rst_sdata", {63'd0, sdata}, 64'd0);
        check("t1_rst_underrun", {63'd0, underrun}, 64'd0);
        check("t1_rst_ready", {63'd0, sample_ready}, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("t1_ready_before_edge", {63'd0, sample_ready}, 64'd0);
        @(negedge clk);
        check("t1_ready_after_release", {63'd0, sample_ready}, 64'd1);

        // 2: bclk period and one full frame
        t0 = -1; per = 0; c = 0; pb = bclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            c++;
            if (!pb && bclk) begin
                if (t0 < 0) t0 = c;
                else begin
                    per = c - t0;
                    break;
                end
            end
            pb = bclk;
        end
        check("t2_bclk_period", per, 64'd4);
        wait_lr_fall(ok);
        check("t2_lr_fall", {63'd0, ok}, 64'd1);
        send(24'h800001, 24'h7FFFFF, ok);
        check("t2_accept", {63'd0, ok}, 64'd1);
        capture(fr, ok);
        check("t2_frame", fr, LIT_T2);

        // 3: back-pressure, pair B offered while A is held
        wait_lr_fall(ok);
        send(24'h123456, 24'h654321, ok_a);
        check("t3_accept_a", {63'd0, ok_a}, 64'd1);
        check("t3_ready_low", {63'd0, sample_ready}, 64'd0);
        fork
            send(24'hABCDEF, 24'h000F00, ok_b);
            capture(fa, ok);
        join
        check("t3_accept_b", {63'd0, ok_b}, 64'd1);
        check("t3_frame_a", fa, LIT_A);
        capture(fb, ok);
        check("t3_frame_b", fb, LIT_B);

        // 4: underrun once per empty frame
        cnt = 0; ones = 0;
        repeat (3 * FRAME * 2 * DIV) begin
            @(negedge clk);
            cnt  += int'(underrun);
            ones += int'(sdata);
        end
        check("t4_underrun_pulses", cnt, 64'd3);
        check("t4_sdata_zero", ones, 64'd0);

        // 5: reset mid-frame at pos 40 of a frame carrying data
        wait_lr_fall(ok);
        send(24'hFFFFFF, 24'hFFFFFF, ok);
        wait_lr_fall(ok);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_pos(m_k) == 40) begin
                found = 1;
                break;
            end
        end
        check("t5_reached_pos40", {63'd0, found}, 64'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_bclk", {63'd0, bclk}, 64'd0);
        check("t5_rst_lrclk", {63'd0, lrclk}, 64'd0);
        check("t5_rst_sdata", {63'd0, sdata}, 64'd0);
        check("t5_rst_underrun", {63'd0, underrun}, 64'd0);
        check("t5_rst_ready", {63'd0, sample_ready}, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cnt = 0; ones = 0;
        repeat (2 * FRAME * 2 * DIV) begin
            @(negedge clk);
            cnt  += int'(underrun);
            ones += int'(sdata);
        end
        check("t5_no_underrun", cnt, 64'd0);
        check("t5_sdata_zero", ones, 64'd0);

        // 6: MSB placement relative to the lrclk edge
        wait_lr_fall(ok);
        send(24'h800000, 24'h000001, ok);
        check("t6_accept", {63'd0, ok}, 64'd1);
        capture(fr, ok);
        check("t6_frame", fr, LIT_T6);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
